storage_port: RTL
=================

# storage_port

- Sits between the CPU's execution stages and the 64-bit doubleword RAM.
- Accepts one byte-addressed load or store of 1, 2, 4 or 8 bytes at a time and turns it into one or two masked doubleword RAM accesses.
- An access that crosses a doubleword boundary is split into two RAM accesses.
- Load data is returned right-justified; store data is merged into the correct byte lanes using big-endian S/370 byte order.

## Interface

Parameters:
- ADDR_WIDTH, 24: width of the CPU byte address. Addresses wrap modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  port can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 8 bytes.
- req_wdata  in  64  store data, right-justified; unused high bytes are ignored.
- resp_valid  out  1  one-cycle pulse when the request completes (loads and stores).
- resp_rdata  out  64  load data, right-justified, high bytes zero; holds its value until the next load completes.
- ram_din  in  64  RAM read data; byte offset 0 is ram_din[63:56].
- ram_ready  in  1  RAM idle / previous command complete.
- ram_dout  out  64  RAM write data, lane-aligned.
- ram_mask  out  8  byte enables; bit 7 = offset 0, bit 0 = offset 7.
- ram_addr  out  28  doubleword index, zero-extended from the ADDR_WIDTH-3 index bits.
- ram_we  out  1  write command.
- ram_re  out  1  read command.

## Operation

Request decoding:
- n = 1 << req_size.
- o = req_addr[2:0].
- split = (o + n > 8).
- First access:
  - index = req_addr[ADDR_WIDTH-1:3];
  - lanes o..min(o+n,8)-1.
- Second access (split only):
  - index + 1, modulo 2^(ADDR_WIDTH-3), so the top doubleword wraps to 0;
  - lanes 0..o+n-9.

Store alignment:
- The request's bytes, most significant first, occupy consecutive lanes starting at lane o, continuing into lane 0 of the next doubleword.
- Non-enabled lanes of ram_dout are 0.

Load merge:
- Bytes are collected from the enabled lanes of each access in address order and right-justified in resp_rdata.

States:
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request and go to ACC1.
- ACC1:
  - ram_addr, ram_mask and ram_dout are driven from registers.
  - When ram_ready = 1, assert ram_re (load) or ram_we (store) combinationally for this cycle and go to WAIT1.
  - Otherwise stay in ACC1 with no command asserted.
- WAIT1: on ram_ready = 1, capture the load lanes and go to ACC2 if split, else to RESP.
- ACC2 and WAIT2: same as ACC1 and WAIT1 for the second access, then go to RESP.
- RESP: resp_valid = 1 (resp_rdata is updated for loads); go to IDLE.

Command and output rules:
- ram_re and ram_we are never both 1.
- ram_re and ram_we are 0 outside ACC1 and ACC2.
- ram_mask is 0 outside ACC and WAIT states.
- ram_addr, ram_mask and ram_dout are stable from ACC entry through the end of the matching WAIT.
- req_ready = 0 in every state except IDLE.
- A request is consumed only in a cycle where req_valid and req_ready are both 1.

Reset:
- While rst = 1: state is IDLE; req_ready, resp_valid, ram_re, ram_we, ram_mask, ram_dout, ram_addr and resp_rdata are all 0.
- Reset mid-operation abandons any RAM access in flight and produces no resp_valid.
- req_ready = 1 in the first cycle after rst falls.

## Timing

Zero-wait RAM (ram_ready held at 1), request accepted at edge 0:
- Unsplit:
  - ram_re/ram_we in cycle 1;
  - data captured at the end of cycle 2;
  - resp_valid in cycle 3;
  - req_ready in cycle 4.
- Split:
  - commands in cycles 1 and 3;
  - resp_valid in cycle 5;
  - req_ready in cycle 6.

Wait states:
- Each cycle ram_ready is 0 during ACC or WAIT adds exactly one cycle.
- The completion cycle is the first cycle after the command with ram_ready = 1.

Throughput: at most one request per 4 cycles (unsplit) or 6 cycles (split).

## Test plan

- Aligned word load:
  - Stimulus: RAM doubleword 0x10 = 0x0011223344556677; load addr 0x14, size 10.
  - Response: ram_addr = 0x2, ram_mask = 0x0F, ram_re for exactly one cycle, resp_rdata = 0x0000000044556677, resp_valid in cycle 3.
- Unaligned halfword store:
  - Stimulus: store addr 0x23, size 01, req_wdata = 0xFFFF_ABCD.
  - Response: ram_addr = 0x4, ram_mask = 0x18, ram_dout = 0x000000ABCD000000, one ram_we, resp_valid.
- Split doubleword load:
  - Stimulus: RAM doubleword 0x00 = 0x0001020304050607 and doubleword 0x08 = 0x08090A0B0C0D0E0F; load addr 0x05, size 11.
  - Response: accesses index 0 with mask 0x07, then index 1 with mask 0xF8; resp_rdata = 0x05060708090A0B0C; resp_valid in cycle 5.
- Split store at the top of the address space:
  - Stimulus: store addr 0xFFFFFE, size 10, data 0xDEADBEEF.
  - Response:
    - first access index 0x1FFFFF, mask 0x03, ram_dout[15:0] = 0xDEAD;
    - second access index 0x000000, mask 0xC0, ram_dout[63:48] = 0xBEEF.
- Wait states:
  - Stimulus: ram_ready held at 0 for 3 cycles after entering ACC1, then 0 for 2 cycles after the command.
  - Response: no command until ram_ready = 1; ram_addr and ram_mask stable throughout; resp_valid is 5 cycles later than in the zero-wait case.
- Reset mid-split:
  - Stimulus: assert rst in WAIT2 of a split load.
  - Response: all outputs 0 the next cycle, no resp_valid, req_ready = 1 one cycle after rst falls, and a following aligned load completes normally.

Source files
------------

// File: rtl/storage_port.sv
// CPU load/store port onto a 64-bit doubleword RAM (big-endian lanes).
// Splits doubleword-crossing accesses, aligns store data and right-justifies load data.
//
// state | meaning
// IDLE  | ready for a request
// ACC1  | first RAM access presented, command issued when ram_ready
// WAIT1 | waiting for first access to complete, load lanes captured
// ACC2  | second RAM access (split requests only)
// WAIT2 | waiting for second access to complete, load data merged
// RESP  | one-cycle completion pulse
module storage_port #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  output logic [63:0]           resp_rdata,
  input  logic [63:0]           ram_din,
  input  logic                  ram_ready,
  output logic [63:0]           ram_dout,
  output logic [7:0]            ram_mask,
  output logic [27:0]           ram_addr,
  output logic                  ram_we,
  output logic                  ram_re
);

  localparam int IW = ADDR_WIDTH - 3;

  typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;

  state_t         state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     off_q, off_d;
  logic [1:0]     size_q, size_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [63:0]    acc_q, acc_d;
  logic [63:0]    resp_rdata_q, resp_rdata_d;
  logic [27:0]    ram_addr_q, ram_addr_d;
  logic [7:0]     ram_mask_q, ram_mask_d;
  logic [63:0]    ram_dout_q, ram_dout_d;

  logic [2:0]     dec_off;
  logic [1:0]     dec_size;
  logic [63:0]    dec_wdata;
  logic [3:0]     n, n1;
  logic [4:0]     sum, n2;
  logic           split;
  logic [7:0]     lane_left, mask1, mask2;
  logic [63:0]    data_left, dout1, dout2;
  logic [63:0]    first_bytes, second_bytes, merged;
  logic [IW-1:0]  idx_next;

  // In IDLE the live request is decoded; afterwards the latched copy is.
  always_comb begin
    dec_off   = (state_q == IDLE) ? req_addr[2:0] : off_q;
    dec_size  = (state_q == IDLE) ? req_size : size_q;
    dec_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    n     = 4'd1 << dec_size;
    sum   = {2'b00, dec_off} + {1'b0, n};
    split = sum > 5'd8;
    n1    = split ? (4'd8 - {1'b0, dec_off}) : n;
    n2    = split ? (sum - 5'd8) : 5'd0;

    lane_left = 8'hFF << (4'd8 - n);
    mask1     = lane_left >> dec_off;
    mask2     = lane_left << (4'd8 - {1'b0, dec_off});

    // Shifting left drops the unused high bytes and left-justifies the rest.
    data_left = dec_wdata << {4'd8 - n, 3'b000};
    dout1     = data_left >> {dec_off, 3'b000};
    dout2     = data_left << {4'd8 - {1'b0, dec_off}, 3'b000};

    first_bytes  = (ram_din << {dec_off, 3'b000}) >> {4'd8 - n1, 3'b000};
    second_bytes = ram_din >> {5'd8 - n2, 3'b000};
    merged       = (acc_q << {n2, 3'b000}) | second_bytes;

    idx_next = idx_q + IW'(1);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    off_d        = off_q;
    size_d       = size_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    resp_rdata_d = resp_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_mask_d   = ram_mask_q;
    ram_dout_d   = ram_dout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = ACC1;
          we_d       = req_we;
          off_d      = req_addr[2:0];
          size_d     = req_size;
          idx_d      = req_addr[ADDR_WIDTH-1:3];
          wdata_d    = req_wdata;
          ram_addr_d = 28'(req_addr[ADDR_WIDTH-1:3]);
          ram_mask_d = mask1;
          ram_dout_d = req_we ? dout1 : 64'd0;
        end
      end
      ACC1: begin
        if (ram_ready) state_d = WAIT1;
      end
      WAIT1: begin
        if (ram_ready) begin
          if (split) begin
            state_d    = ACC2;
            acc_d      = first_bytes;
            ram_addr_d = 28'(idx_next);
            ram_mask_d = mask2;
            ram_dout_d = we_q ? dout2 : 64'd0;
          end else begin
            state_d    = RESP;
            ram_addr_d = 28'd0;
            ram_mask_d = 8'd0;
            ram_dout_d = 64'd0;
            if (!we_q) resp_rdata_d = first_bytes;
          end
        end
      end
      ACC2: begin
        if (ram_ready) state_d = WAIT2;
      end
      WAIT2: begin
        if (ram_ready) begin
          state_d    = RESP;
          ram_addr_d = 28'd0;
          ram_mask_d = 8'd0;
          ram_dout_d = 64'd0;
          if (!we_q) resp_rdata_d = merged;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      off_q        <= 3'd0;
      size_q       <= 2'd0;
      idx_q        <= '0;
      wdata_q      <= 64'd0;
      acc_q        <= 64'd0;
      resp_rdata_q <= 64'd0;
      ram_addr_q   <= 28'd0;
      ram_mask_q   <= 8'd0;
      ram_dout_q   <= 64'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      off_q        <= off_d;
      size_q       <= size_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      acc_q        <= acc_d;
      resp_rdata_q <= resp_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_mask_q   <= ram_mask_d;
      ram_dout_q   <= ram_dout_d;
    end
  end

  // Handshake and command strobes are gated by rst so they read 0 for the whole reset.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP) && !rst;
  assign ram_re     = !rst && ram_ready && !we_q && ((state_q == ACC1) || (state_q == ACC2));
  assign ram_we     = !rst && ram_ready &&  we_q && ((state_q == ACC1) || (state_q == ACC2));
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_mask   = ram_mask_q;
  assign ram_dout   = ram_dout_q;

endmodule
